// File: rtl/ptp_b_readout_seq.sv
// Sequencer driving the type-B serialiser on the Baby RAM/address outputs from a slow host handshake.
// Optional hold timeout is built when PTP_SEQ_TIMEOUT_EN is defined.
module ptp_b_readout_seq #(
  parameter int PULSE_HIGH     = 1,
  parameter int SERIAL_BEATS   = 160,
  parameter int BYTE_BEATS     = 20,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       start_i,
  input  logic       mode_i,
  input  logic       ack_i,
  input  logic       abort_i,
  output logic       ptp_reset_o,
  output logic       ptp_control_o,
  output logic       ptp_serial_o,
  output logic       beat_valid_o,
  output logic [7:0] beat_idx_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o
);

  if (PULSE_HIGH < 1 || PULSE_HIGH > 256 || SERIAL_BEATS < 1 || SERIAL_BEATS > 256 ||
      BYTE_BEATS < 1 || BYTE_BEATS > 256 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_param
    $error("ptp_b_readout_seq: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_PULSE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] pulse_q, pulse_d;
  logic       mode_q, mode_d;
  logic       rst_hold_q;
  logic       last_beat;
  logic       timeout_hit;

  assign last_beat = mode_q ? (idx_q == 8'(SERIAL_BEATS - 1))
                            : (idx_q == 8'(BYTE_BEATS - 1));

  // Holds ptp_reset_o high for the cycle after any reset edge, before IDLE takes over.
  always_ff @(posedge clk_i) begin
    rst_hold_q <= ~reset_n_i;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      pulse_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pulse_q <= pulse_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    pulse_d       = pulse_q;
    mode_d        = mode_q;
    ptp_control_o = 1'b0;
    beat_valid_o  = 1'b0;
    busy_o        = 1'b0;
    done_o        = 1'b0;
    ptp_reset_o   = rst_hold_q;

    case (state_q)
      S_IDLE: begin
        // start beats abort here; abort only matters once a frame is running
        if (start_i) begin
          mode_d  = mode_i;
          idx_d   = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        ptp_reset_o = 1'b1;
        busy_o      = 1'b1;
        if (abort_i) begin
          state_d = S_IDLE;
        end else begin
          pulse_d = '0;
          state_d = S_PULSE;
        end
      end
      S_PULSE: begin
        ptp_control_o = 1'b1;
        busy_o        = 1'b1;
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (pulse_q == 8'(PULSE_HIGH - 1)) begin
          state_d = S_HOLD;
        end else begin
          pulse_d = pulse_q + 8'd1;
        end
      end
      S_HOLD: begin
        beat_valid_o = 1'b1;
        busy_o       = 1'b1;
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (ack_i) begin
          if (last_beat) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 8'd1;
            pulse_d = '0;
            state_d = S_PULSE;
          end
        end else if (timeout_hit) begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ptp_serial_o = mode_q;
  assign beat_idx_o   = idx_q;

`ifdef PTP_SEQ_TIMEOUT_EN
  logic [7:0] wait_q;
  logic       error_q;

  // wait_q is zero on every HOLD entry because it only counts while in HOLD.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wait_q  <= '0;
      error_q <= 1'b0;
    end else begin
      if (state_q == S_HOLD) begin
        wait_q <= wait_q + 8'd1;
      end else begin
        wait_q <= '0;
      end
      if (state_q == S_IDLE && start_i) begin
        error_q <= 1'b0;
      end else if (state_q == S_HOLD && !abort_i && !ack_i && timeout_hit) begin
        error_q <= 1'b1;
      end
    end
  end

  assign timeout_hit = (wait_q == 8'(TIMEOUT_CYCLES - 1));
  assign error_o     = error_q;
`else
  assign timeout_hit = 1'b0;
  assign error_o     = 1'b0;
`endif

endmodule

// File: tb/tb_ptp_b_readout_seq.sv
// Randomized bench for ptp_b_readout_seq; frame-level expectations (beats, index order, edges, latency).
module tb_ptp_b_readout_seq;
`ifdef PTP_SEQ_TIMEOUT_EN
  localparam int TO_CYC = 4;
`else
  localparam int TO_CYC = 255;
`endif
  localparam int PH = 1;
  localparam int SB = 160;
  localparam int BB = 20;

  logic       clk = 1'b0;
  logic       reset_n, start, mode, ack, abort;
  logic       ptp_reset, ctrl, serial, valid, busy, done, error;
  logic [7:0] idx;

  int n_vec = 0;
  int n_bad = 0;
  int edges, dones, hi_run;
  logic ctrl_prev;

  always #5 clk = ~clk;

  ptp_b_readout_seq #(
    .PULSE_HIGH    (PH),
    .SERIAL_BEATS  (SB),
    .BYTE_BEATS    (BB),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .start_i      (start),
    .mode_i       (mode),
    .ack_i        (ack),
    .abort_i      (abort),
    .ptp_reset_o  (ptp_reset),
    .ptp_control_o(ctrl),
    .ptp_serial_o (serial),
    .beat_valid_o (valid),
    .beat_idx_o   (idx),
    .busy_o       (busy),
    .done_o       (done),
    .error_o      (error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one cycle and sample at the falling edge, tracking control edges and done pulses.
  task automatic step();
    @(negedge clk);
    if (ctrl === 1'b1 && ctrl_prev !== 1'b1) edges++;
    if (ctrl === 1'b1) begin
      hi_run++;
      chk("ctrl_during_clear", ptp_reset, 0);
    end else if (ctrl_prev === 1'b1) begin
      chk("pulse_width", hi_run, PH);
      hi_run = 0;
    end
    if (done === 1'b1) dones++;
    ctrl_prev = ctrl;
  endtask

  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (valid === 1'b1) begin
        n = i;
        break;
      end
    end
    if (n < 0) chk("valid_wait", 0, 1);
  endtask

  task automatic recover();
    reset_n = 1'b0; start = 1'b0; ack = 1'b0; abort = 1'b0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic run_frame(input bit m, input int dmin, input int dmax, input int abort_at,
                           input int reset_at, input bit toggle, input bit hold_ack, input bit keep);
    int beats, n, dly;
    beats = m ? SB : BB;
    edges = 0;
    dones = 0;
    start = 1'b1;
    mode  = m;
    abort = ($urandom_range(0, 3) == 0);
    step();
    chk("clr_ptp_reset", ptp_reset, 1);
    chk("clr_busy", busy, 1);
    chk("clr_ctrl", ctrl, 0);
    chk("clr_error", error, 0);
    abort = 1'b0;
    for (int b = 0; b < beats; b++) begin
      start = keep ? 1'b1 : 1'($urandom_range(0, 1));
      if (toggle) mode = 1'($urandom_range(0, 1));
      wait_valid(n);
      if (n < 0) begin
        recover();
        return;
      end
      if (b == 0) chk("latency", n, 1 + PH);
      else        chk("beat_gap", n, PH);
      chk("beat_idx", idx, b);
      chk("edges_at_beat", edges, b + 1);
      chk("serial", serial, m);
      chk("busy_hold", busy, 1);
      if (b == reset_at) begin
        reset_n = 1'b0;
        start   = 1'b0;
        ack     = 1'($urandom_range(0, 1));
        step();
        chk("rst_ptp_reset", ptp_reset, 1);
        chk("rst_ctrl", ctrl, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_idx", idx, 0);
        chk("rst_serial", serial, 0);
        chk("rst_done", done, 0);
        reset_n = 1'b1;
        ack     = 1'b0;
        step();
        chk("rst_release", ptp_reset, 0);
        chk("rst_idle_busy", busy, 0);
        return;
      end
      if (ack !== 1'b1) begin
        dly = $urandom_range(dmin, dmax);
        for (int i = 0; i < dly; i++) begin
          step();
          chk("valid_held", valid, 1);
        end
      end
      ack = 1'b1;
      if (b == abort_at) begin
        abort = 1'b1;
        start = 1'b0;
      end
      if (b == beats - 1) start = keep;
      step();
      if (b == abort_at) begin
        chk("abort_busy", busy, 0);
        chk("abort_valid", valid, 0);
        chk("abort_ctrl", ctrl, 0);
        chk("abort_done", done, 0);
        abort = 1'b0;
        ack   = 1'b0;
        repeat (4) step();
        chk("abort_edges", edges, b + 1);
        chk("abort_dones", dones, 0);
        return;
      end
      chk("ack_drop", valid, 0);
      if (b == beats - 1) begin
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
      end else begin
        chk("next_pulse", ctrl, 1);
      end
      ack = hold_ack;
    end
    ack = 1'b0;
    step();
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("frame_dones", dones, 1);
    chk("frame_edges", edges, beats);
    if (keep) begin
      step();
      chk("restart_busy", busy, 1);
      chk("restart_clr", ptp_reset, 1);
      start = 1'b0;
      abort = 1'b1;
      step();
      chk("restart_abort", busy, 0);
      abort = 1'b0;
    end else begin
      ack = 1'b1;
      step();
      chk("ack_idle_ignored", busy, 0);
      ack = 1'b0;
    end
  endtask

`ifdef PTP_SEQ_TIMEOUT_EN
  task automatic timeout_test();
    int n, held;
    dones = 0;
    start = 1'b1; mode = 1'b0;
    step();
    start = 1'b0;
    wait_valid(n);
    if (n < 0) begin
      recover();
      return;
    end
    held = 1;
    while (valid === 1'b1 && held < 20) begin
      step();
      if (valid === 1'b1) held++;
    end
    chk("to_hold_cycles", held, TO_CYC);
    chk("to_error", error, 1);
    chk("to_busy", busy, 0);
    chk("to_dones", dones, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("to_error_clear", error, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask
`endif

  initial begin
    bit m;
    int ab, rs, nb;
    reset_n = 1'b0; start = 1'b0; mode = 1'b0; ack = 1'b0; abort = 1'b0;
    edges = 0; dones = 0; hi_run = 0; ctrl_prev = 1'b0;
    step();
    step();
    chk("reset_ptp_reset", ptp_reset, 1);
    chk("reset_ctrl", ctrl, 0);
    chk("reset_serial", serial, 0);
    chk("reset_valid", valid, 0);
    chk("reset_idx", idx, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_error", error, 0);
    reset_n = 1'b1;
    step();
    chk("idle_ptp_reset", ptp_reset, 0);

    run_frame(1'b0, 2, 2, -1, -1, 1'b0, 1'b0, 1'b0);
    run_frame(1'b1, 0, 3, -1, -1, 1'b1, 1'b0, 1'b0);
    run_frame(1'b0, 0, 3, 7, -1, 1'b0, 1'b0, 1'b0);
    run_frame(1'b1, 0, 2, -1, 3, 1'b0, 1'b0, 1'b0);
    run_frame(1'b0, 0, 1, -1, -1, 1'b1, 1'b1, 1'b1);
`ifdef PTP_SEQ_TIMEOUT_EN
    timeout_test();
`endif
    for (int k = 0; k < 8; k++) begin
      m  = 1'($urandom_range(0, 1));
      nb = m ? SB : BB;
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      rs = (ab < 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      run_frame(m, 0, 3, ab, rs, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
